time_bin_sequencer: RTL and testbench

TIME_BIN_SEQUENCER -- requirements
Module: time_bin_sequencer

---
 rtl/time_bin_sequencer_if.sv | 44 ++++
 rtl/time_bin_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_time_bin_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_bin_sequencer_if.sv
// Bin output bus of time_bin_sequencer: latched bin count and index under a
// valid/ready handshake. With TIMESTAMP_EN defined the bus also carries bin_time.
interface time_bin_sequencer_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned IDX_W = 8
);
    logic             bin_valid;
    logic             bin_ready;
    logic [CNT_W-1:0] bin_data;
    logic [IDX_W-1:0] bin_index;
`ifdef TIMESTAMP_EN
    logic [31:0]      bin_time;

    modport master (
        output bin_valid,
        output bin_data,
        output bin_index,
        output bin_time,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_data,
        input  bin_index,
        input  bin_time,
        output bin_ready
    );
`else
    modport master (
        output bin_valid,
        output bin_data,
        output bin_index,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_data,
        input  bin_index,
        output bin_ready
    );
`endif
endinterface

// File: rtl/time_bin_sequencer.sv
// Time-bin photon counting sequencer. Per bin it clears the external PMT
// counter, opens the gate for L cycles, latches the count and offers it on a
// valid/ready bus. The gate stays closed while a bin waits for the consumer.
// Optional feature: define TIMESTAMP_EN to add bin_time, the free-running cycle
// count sampled on the first gate cycle of each bin.
module time_bin_sequencer #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned LEN_W = 24,
    parameter int unsigned IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_W-1:0]        bin_len,
    input  logic [IDX_W-1:0]        num_bins,
    input  logic [CNT_W-1:0]        cnt_value,
    output logic                    cnt_clear,
    output logic                    gate,
    output logic                    busy,
    output logic                    done,
    time_bin_sequencer_if.master    bin_if
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCount,
        StLatch,
        StHold,
        StFinish
    } state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0] len_q, len_d;          // effective gate length, never 0
    logic [IDX_W-1:0] nbins_q, nbins_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;  // gate cycles already spent in this bin
    logic [IDX_W-1:0] cur_bin_q, cur_bin_d;
    logic [CNT_W-1:0] bin_data_q, bin_data_d;
    logic [IDX_W-1:0] bin_index_q, bin_index_d;

    logic last_gate;
    logic last_bin;

    assign last_gate = (len_cnt_q == len_q - LEN_W'(1));
    // Full-width compare so a maximal num_bins never wraps the index.
    assign last_bin  = (cur_bin_q == nbins_q - IDX_W'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_bins == '0) ? StFinish : StClear;
                end
            end
            StClear:  state_d = StCount;
            StCount: begin
                if (last_gate) begin
                    state_d = StLatch;
                end
            end
            StLatch:  state_d = StHold;
            StHold: begin
                if (bin_if.bin_ready) begin
                    state_d = last_bin ? StFinish : StClear;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // Outputs decoded from the state; abort masks valid/done so it wins the cycle.
    always_comb begin
        cnt_clear        = 1'b0;
        gate             = 1'b0;
        busy             = (state_q != StIdle);
        done             = 1'b0;
        bin_if.bin_valid = 1'b0;
        unique case (state_q)
            StIdle:   cnt_clear = 1'b1;
            StClear:  cnt_clear = 1'b1;
            StCount:  gate = 1'b1;
            StLatch:  ;
            StHold:   bin_if.bin_valid = ~abort;
            StFinish: done = ~abort;
            default:  ;
        endcase
    end

    // Datapath next-state: config capture, gate length count, bin latch.
    always_comb begin
        len_d       = len_q;
        nbins_d     = nbins_q;
        len_cnt_d   = len_cnt_q;
        cur_bin_d   = cur_bin_q;
        bin_data_d  = bin_data_q;
        bin_index_d = bin_index_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    len_d     = (bin_len == '0) ? LEN_W'(1) : bin_len;
                    nbins_d   = num_bins;
                    cur_bin_d = '0;
                end
            end
            StClear:  len_cnt_d = '0;
            StCount:  len_cnt_d = len_cnt_q + LEN_W'(1);
            StLatch: begin
                bin_data_d  = cnt_value;
                bin_index_d = cur_bin_q;
            end
            StHold: begin
                if (bin_if.bin_ready && !abort && !last_bin) begin
                    cur_bin_d = cur_bin_q + IDX_W'(1);
                end
            end
            StFinish: ;
            default:  ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q       <= LEN_W'(1);
            nbins_q     <= '0;
            len_cnt_q   <= '0;
            cur_bin_q   <= '0;
            bin_data_q  <= '0;
            bin_index_q <= '0;
        end else begin
            len_q       <= len_d;
            nbins_q     <= nbins_d;
            len_cnt_q   <= len_cnt_d;
            cur_bin_q   <= cur_bin_d;
            bin_data_q  <= bin_data_d;
            bin_index_q <= bin_index_d;
        end
    end

    assign bin_if.bin_data  = bin_data_q;
    assign bin_if.bin_index = bin_index_q;

`ifdef TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] bin_time_q, bin_time_d;

    // Free-running timestamp, sampled on the first gate cycle of a bin.
    always_comb begin
        ts_d       = ts_q + 32'd1;
        bin_time_d = bin_time_q;
        if (state_q == StCount && len_cnt_q == '0) begin
            bin_time_d = ts_q;
        end
    end

    // Timestamp registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            bin_time_q <= '0;
        end else begin
            ts_q       <= ts_d;
            bin_time_q <= bin_time_d;
        end
    end

    assign bin_if.bin_time = bin_time_q;
`endif

endmodule

// File: tb/tb_time_bin_sequencer.sv
// Self-checking bench for time_bin_sequencer: table-driven acquisitions plus
// hand-written abort and reset sequences. A small PMT counter model supplies
// cnt_value: a burst on the first gate cycle of a bin plus a step per gate cycle.
module tb_time_bin_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [23:0] bin_len;
    logic [7:0]  num_bins;
    logic [31:0] cnt_value;
    logic        cnt_clear;
    logic        gate;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    int burst = 0;
    int step  = 0;
    logic gate_seen;

    time_bin_sequencer_if #(.CNT_W(32), .IDX_W(8)) bin_if ();

    time_bin_sequencer #(
        .CNT_W(32),
        .LEN_W(24),
        .IDX_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .bin_len   (bin_len),
        .num_bins  (num_bins),
        .cnt_value (cnt_value),
        .cnt_clear (cnt_clear),
        .gate      (gate),
        .busy      (busy),
        .done      (done),
        .bin_if    (bin_if)
    );

    always #5 clk = ~clk;

    // External counter model: async clear, counts only while gated.
    always @(posedge clk or posedge cnt_clear) begin
        if (cnt_clear) begin
            cnt_value <= '0;
            gate_seen <= 1'b0;
        end else if (gate) begin
            cnt_value <= cnt_value + 32'(step) + (gate_seen ? 32'd0 : 32'(burst));
            gate_seen <= 1'b1;
        end
    end

    typedef struct {
        int len;
        int nb;
        int burst;
        int step;
        int stall;
        int exp_gate_run;
        int exp_nvalid;
        int exp_data;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance one clock; sample point sits 2 time units after the edge.
    task automatic step_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_acq(input vec_t v);
        int   gates_in_bin;
        int   last_gate_cyc;
        int   nvalid;
        int   ndone;
        int   stall_left;
        int   done_cyc;
        bit   finished;
        bit   prev_valid;
        bit   prev_stall;
        bit   prev_busy;
        logic [31:0] held_data;
        logic [7:0]  held_index;
`ifdef TIMESTAMP_EN
        logic [31:0] prev_time;
`endif
        gates_in_bin  = 0;
        last_gate_cyc = -100;
        nvalid        = 0;
        ndone         = 0;
        stall_left    = v.stall;
        done_cyc      = -1;
        finished      = 0;
        prev_valid    = 0;
        prev_stall    = 0;
        prev_busy     = 1;
        held_data     = '0;
        held_index    = '0;
        burst         = v.burst;
        step          = v.step;
        bin_len       = 24'(v.len);
        num_bins      = 8'(v.nb);
        bin_ready_set(1'b1);
        start         = 1'b1;
        step_cycle();
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (cyc > 0) step_cycle();
            // Disturb config and pulse start while busy; none of it may matter.
            bin_len  = 24'($urandom_range(0, 15));
            num_bins = 8'($urandom_range(0, 15));
            start    = prev_busy && (cyc % 3 == 0);
            bin_ready_set(stall_left == 0);
            #1;
            prev_busy = busy;
            if (gate) begin
                gates_in_bin++;
                last_gate_cyc = cyc;
                check("gate_vs_clear", cnt_clear, 0);
            end
            if (bin_if.bin_valid && !prev_valid) begin
                check("valid_latency", cyc - last_gate_cyc, 2);
                check("gate_run", gates_in_bin, v.exp_gate_run);
                gates_in_bin = 0;
            end
            if (bin_if.bin_valid && !bin_if.bin_ready) begin
                check("stall_gate", gate, 0);
                if (prev_stall) begin
                    check("stall_data", bin_if.bin_data, held_data);
                    check("stall_index", bin_if.bin_index, held_index);
                end
                held_data  = bin_if.bin_data;
                held_index = bin_if.bin_index;
                stall_left--;
            end
            prev_stall = bin_if.bin_valid && !bin_if.bin_ready;
            if (bin_if.bin_valid && bin_if.bin_ready) begin
                check("bin_data", bin_if.bin_data, v.exp_data);
                check("bin_index", bin_if.bin_index, nvalid);
`ifdef TIMESTAMP_EN
                if (nvalid > 0 && v.stall == 0) begin
                    check("bin_period", bin_if.bin_time - prev_time, v.exp_gate_run + 3);
                end
                prev_time = bin_if.bin_time;
`endif
                nvalid++;
            end
            prev_valid = bin_if.bin_valid;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                finished = 1;
            end
        end
        start = 1'b0;
        check("acq_finished", finished, 1);
        check("nvalid", nvalid, v.exp_nvalid);
        check("ndone", ndone, 1);
        check("gate_leftover", gates_in_bin, 0);
        if (v.nb == 0) check("done_latency", done_cyc, 0);
        step_cycle();
        check("idle_after_done", busy, 0);
        check("clear_after_done", cnt_clear, 1);
    endtask

    task automatic bin_ready_set(input logic r);
        bin_if.bin_ready = r;
    endtask

    // Run n cycles checking that nothing is produced.
    task automatic quiet_cycles(input int n, input string tag);
        int nv;
        int nd;
        int ng;
        nv = 0;
        nd = 0;
        ng = 0;
        for (int i = 0; i < n; i++) begin
            step_cycle();
            if (bin_if.bin_valid) nv++;
            if (done) nd++;
            if (gate) ng++;
        end
        check({tag, "_no_valid"}, nv, 0);
        check({tag, "_no_done"}, nd, 0);
        check({tag, "_no_gate"}, ng, 0);
    endtask

    vec_t vecs[6];

    initial begin
        bit found;
        int hs;

        vecs[0] = '{len: 4, nb: 3, burst: 1, step: 1, stall: 0,
                    exp_gate_run: 4, exp_nvalid: 3, exp_data: 5};
        vecs[1] = '{len: 0, nb: 1, burst: 3, step: 2, stall: 0,
                    exp_gate_run: 1, exp_nvalid: 1, exp_data: 5};
        vecs[2] = '{len: 2, nb: 2, burst: 0, step: 3, stall: 10,
                    exp_gate_run: 2, exp_nvalid: 2, exp_data: 6};
        vecs[3] = '{len: 5, nb: 0, burst: 1, step: 1, stall: 0,
                    exp_gate_run: 0, exp_nvalid: 0, exp_data: 0};
        vecs[4] = '{len: 7, nb: 5, burst: 2, step: 1, stall: 0,
                    exp_gate_run: 7, exp_nvalid: 5, exp_data: 9};
        vecs[5] = '{len: 1, nb: 2, burst: 0, step: 0, stall: 0,
                    exp_gate_run: 1, exp_nvalid: 2, exp_data: 0};

        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        bin_len  = '0;
        num_bins = '0;
        bin_ready_set(1'b0);
        #1;
        check("rst_clear", cnt_clear, 1);
        check("rst_gate", gate, 0);
        check("rst_valid", bin_if.bin_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_data", bin_if.bin_data, 0);
        check("rst_index", bin_if.bin_index, 0);
        step_cycle();
        step_cycle();
        reset = 1'b0;
        step_cycle();

        for (int i = 0; i < 6; i++) begin
            run_acq(vecs[i]);
        end

        // Abort during the gate of bin 1 of 4.
        burst    = 2;
        step     = 1;
        bin_len  = 24'd3;
        num_bins = 8'd4;
        bin_ready_set(1'b1);
        start    = 1'b1;
        step_cycle();
        start = 1'b0;
        hs    = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (gate && hs == 1) begin
                found = 1;
            end else begin
                if (bin_if.bin_valid && bin_if.bin_ready) hs++;
                step_cycle();
            end
        end
        check("abort_reach", found, 1);
        abort = 1'b1;
        step_cycle();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_clear", cnt_clear, 1);
        check("abort_gate", gate, 0);
        quiet_cycles(20, "abort");
        run_acq(vecs[0]);

        // Abort in HOLD with ready high: abort beats the handshake.
        bin_len  = 24'd1;
        num_bins = 8'd2;
        start    = 1'b1;
        step_cycle();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bin_if.bin_valid) found = 1;
            else step_cycle();
        end
        check("hold_reach", found, 1);
        abort = 1'b1;
        #1;
        check("abort_hold_valid", bin_if.bin_valid, 0);
        step_cycle();
        abort = 1'b0;
        check("abort_hold_busy", busy, 0);
        quiet_cycles(10, "abort_hold");

        // Simultaneous start and abort in IDLE: stays idle.
        start = 1'b1;
        abort = 1'b1;
        step_cycle();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);

        // Asynchronous reset mid-gate discards the bin.
        bin_len  = 24'd5;
        num_bins = 8'd2;
        start    = 1'b1;
        step_cycle();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (gate) found = 1;
            else step_cycle();
        end
        check("reset_reach", found, 1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_clear", cnt_clear, 1);
        check("mid_rst_gate", gate, 0);
        check("mid_rst_valid", bin_if.bin_valid, 0);
        check("mid_rst_data", bin_if.bin_data, 0);
        check("mid_rst_index", bin_if.bin_index, 0);
        step_cycle();
        reset = 1'b0;
        quiet_cycles(15, "post_reset");
        run_acq(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
